// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding and
// the PC step helper used to advance one instruction at a time.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RESP = 2'd1,
    WAIT_FILL = 2'd2,
    WAIT_DONE = 2'd3
  } fetch_state_t;

  localparam int DATA_BITWIDTH_DEFAULT = 32;

  function automatic int instr_bytes(input int data_bitwidth);
    return data_bitwidth / 8;
  endfunction

  localparam int INSTR_BYTES = instr_bytes(DATA_BITWIDTH_DEFAULT);

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: redirect input, instruction cache request/response
// and the valid/ready instruction stream towards decode.
interface instruction_fetch_if #(
  parameter int ADDRESS_BITWIDTH = 32,
  parameter int DATA_BITWIDTH    = 32
);
  logic                        redirect;
  logic [ADDRESS_BITWIDTH-1:0] redirect_pc;

  logic                        ic_enable;
  logic [ADDRESS_BITWIDTH-1:0] ic_address;
  logic [DATA_BITWIDTH-1:0]    ic_data;
  logic                        ic_data_ready;
  logic                        ic_busy;

  logic                        instr_valid;
  logic [DATA_BITWIDTH-1:0]    instr;
  logic [ADDRESS_BITWIDTH-1:0] instr_pc;
  logic                        instr_ready;

  modport master (
    input  redirect, redirect_pc,
    output ic_enable, ic_address,
    input  ic_data, ic_data_ready, ic_busy,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    output redirect, redirect_pc,
    input  ic_enable, ic_address,
    output ic_data, ic_data_ready, ic_busy,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/instruction_fetch_fifo.sv
// Small synchronous FIFO holding {instruction, pc} pairs; flush has priority
// over push and pop, and the head reads as zero while empty.
module instruction_fifo #(
  parameter int WIDTH          = 64,
  parameter int DEPTH_BITWIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  input  logic                    flush,
  output logic [DEPTH_BITWIDTH:0] count,
  output logic                    head_valid,
  output logic [WIDTH-1:0]        head
);
  localparam int DEPTH = 1 << DEPTH_BITWIDTH;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [DEPTH_BITWIDTH-1:0] wr_ptr;
  logic [DEPTH_BITWIDTH-1:0] rd_ptr;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; only pointers and count do, and the
  // head is gated while empty so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_valid = (count != '0);
  assign head       = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding instruction-cache read at a time, responses
// queued with their PC for decode; redirect flushes and drops in-flight data.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                          ADDRESS_BITWIDTH    = 32,
  parameter int                          DATA_BITWIDTH       = DATA_BITWIDTH_DEFAULT,
  parameter logic [ADDRESS_BITWIDTH-1:0] RESET_PC            = '0,
  parameter int                          FIFO_DEPTH_BITWIDTH = 2
) (
  input logic                 clk,
  input logic                 rst,
  instruction_fetch_if.master bus
);
  localparam int ENTRY_BITWIDTH = DATA_BITWIDTH + ADDRESS_BITWIDTH;
  localparam logic [ADDRESS_BITWIDTH-1:0] PC_STEP =
    ADDRESS_BITWIDTH'(instr_bytes(DATA_BITWIDTH));
  localparam logic [FIFO_DEPTH_BITWIDTH:0] FIFO_DEPTH =
    {1'b1, {FIFO_DEPTH_BITWIDTH{1'b0}}};

  fetch_state_t                 state, next_state;
  logic [ADDRESS_BITWIDTH-1:0]  pc, req_pc;
  logic                         discard;
  logic                         issue, response, push, pop;
  logic                         fifo_valid;
  logic [FIFO_DEPTH_BITWIDTH:0] fifo_count;
  logic [ENTRY_BITWIDTH-1:0]    fifo_head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (!bus.ic_busy && fifo_count < FIFO_DEPTH && !bus.redirect)
                   next_state = WAIT_RESP;
      WAIT_RESP: if (bus.ic_busy)            next_state = WAIT_FILL;
                 else if (bus.ic_data_ready) next_state = IDLE;
      WAIT_FILL: if (bus.ic_data_ready)      next_state = bus.ic_busy ? WAIT_DONE : IDLE;
      WAIT_DONE: if (!bus.ic_busy)           next_state = IDLE;
      default:                               next_state = IDLE;
    endcase
  end

  // Nothing is in flight while IDLE, so the FIFO count alone bounds issue.
  always_comb begin
    issue    = 1'b0;
    response = 1'b0;
    case (state)
      IDLE:      issue    = !bus.ic_busy && fifo_count < FIFO_DEPTH && !bus.redirect;
      WAIT_RESP: response = !bus.ic_busy && bus.ic_data_ready;
      WAIT_FILL: response = bus.ic_data_ready;
      default:   ;
    endcase
  end

  assign push = response && !discard && !bus.redirect;
  assign pop  = fifo_valid && bus.instr_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc             <= RESET_PC;
      req_pc         <= '0;
      discard        <= 1'b0;
      bus.ic_enable  <= 1'b0;
      bus.ic_address <= '0;
    end else begin
      bus.ic_enable <= issue;
      if (issue) begin
        bus.ic_address <= pc;
        req_pc         <= pc;
      end
      if (bus.redirect) pc <= bus.redirect_pc;
      else if (issue)   pc <= pc + PC_STEP;
      // A redirect while a response is outstanding poisons that response.
      if (next_state == IDLE)
        discard <= 1'b0;
      else if (bus.redirect && (state == WAIT_RESP || state == WAIT_FILL))
        discard <= 1'b1;
    end
  end

  instruction_fifo #(
    .WIDTH          (ENTRY_BITWIDTH),
    .DEPTH_BITWIDTH (FIFO_DEPTH_BITWIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  ({bus.ic_data, req_pc}),
    .pop        (pop),
    .flush      (bus.redirect),
    .count      (fifo_count),
    .head_valid (fifo_valid),
    .head       (fifo_head)
  );

  assign bus.instr_valid = fifo_valid;
  assign bus.instr       = fifo_head[ENTRY_BITWIDTH-1:ADDRESS_BITWIDTH];
  assign bus.instr_pc    = fifo_head[ADDRESS_BITWIDTH-1:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a reactive cache model: hits answer
// in the request cycle, misses fill for 6 cycles with data on fill cycle 3.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam int          FILL_LEN = 6;
  localparam logic [31:0] DATA_KEY = 32'hDEAD_0000;

  logic clk = 1'b0;
  logic rst;
  logic miss_mode;
  int   fill_cycle;
  int   checks   = 0;
  int   failures = 0;

  instruction_fetch_if #(.ADDRESS_BITWIDTH(32), .DATA_BITWIDTH(32)) bus ();

  instruction_fetch #(
    .ADDRESS_BITWIDTH    (32),
    .DATA_BITWIDTH       (32),
    .RESET_PC            (32'h0000_0100),
    .FIFO_DEPTH_BITWIDTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Cache model: fill cycle 1 is the request cycle itself.
  always @(posedge clk or negedge rst) begin
    if (!rst)                             fill_cycle <= 0;
    else if (bus.ic_enable && miss_mode)  fill_cycle <= 2;
    else if (fill_cycle == FILL_LEN)      fill_cycle <= 0;
    else if (fill_cycle != 0)             fill_cycle <= fill_cycle + 1;
  end

  assign bus.ic_busy       = (bus.ic_enable && miss_mode) || (fill_cycle != 0);
  assign bus.ic_data_ready = bus.ic_enable ? !miss_mode : (fill_cycle == 0 || fill_cycle >= 3);
  assign bus.ic_data       = bus.ic_address ^ DATA_KEY;

  task automatic restart(input logic [31:0] start_pc, input logic miss);
    @(negedge clk);
    rst = 1'b0; miss_mode = miss; bus.redirect = 1'b0; bus.instr_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = start_pc;
    @(negedge clk);
    bus.redirect = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; miss_mode = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.ic_enable !== 1'b0) begin failures++; $display("FAIL reset ic_enable: got %b want 0", bus.ic_enable); end
    checks++; if (bus.ic_address !== 32'h0) begin failures++; $display("FAIL reset ic_address: got %h want 0", bus.ic_address); end
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL reset instr_valid: got %b want 0", bus.instr_valid); end
    checks++; if (bus.instr !== 32'h0) begin failures++; $display("FAIL reset instr: got %h want 0", bus.instr); end
    checks++; if (bus.instr_pc !== 32'h0) begin failures++; $display("FAIL reset instr_pc: got %h want 0", bus.instr_pc); end
    rst = 1'b1;
  endtask

  task automatic test_hit_stream();
    logic [31:0] exp_pc;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++; if (bus.ic_enable !== 1'(k % 2)) begin failures++; $display("FAIL hit ic_enable cycle %0d: got %b want %b", k, bus.ic_enable, 1'(k % 2)); end
      if (k % 2 == 1) begin
        exp_pc = 32'h100 + 32'(INSTR_BYTES * ((k - 1) / 2));
        checks++; if (bus.ic_address !== exp_pc) begin failures++; $display("FAIL hit ic_address cycle %0d: got %h want %h", k, bus.ic_address, exp_pc); end
      end else begin
        exp_pc = 32'h100 + 32'(INSTR_BYTES * (k / 2 - 1));
        checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL hit instr_valid cycle %0d: got %b want 1", k, bus.instr_valid); end
        checks++; if (bus.instr_pc !== exp_pc) begin failures++; $display("FAIL hit instr_pc cycle %0d: got %h want %h", k, bus.instr_pc, exp_pc); end
        checks++; if (bus.instr !== (exp_pc ^ DATA_KEY)) begin failures++; $display("FAIL hit instr cycle %0d: got %h want %h", k, bus.instr, exp_pc ^ DATA_KEY); end
      end
    end
  endtask

  task automatic test_miss();
    logic exp_en, exp_valid;
    restart(32'h200, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      exp_en    = (k == 1 || k == 9);
      exp_valid = (k == 4);
      checks++; if (bus.ic_enable !== exp_en) begin failures++; $display("FAIL miss ic_enable cycle %0d: got %b want %b", k, bus.ic_enable, exp_en); end
      checks++; if (bus.instr_valid !== exp_valid) begin failures++; $display("FAIL miss instr_valid cycle %0d: got %b want %b", k, bus.instr_valid, exp_valid); end
      if (k == 4) begin
        checks++; if (bus.instr_pc !== 32'h200) begin failures++; $display("FAIL miss instr_pc: got %h want 00000200", bus.instr_pc); end
      end
      if (k == 9) begin
        checks++; if (bus.ic_address !== 32'h204) begin failures++; $display("FAIL miss next ic_address: got %h want 00000204", bus.ic_address); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic exp_en;
    restart(32'h300, 1'b0);
    bus.instr_ready = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_en = (k == 1 || k == 3 || k == 5 || k == 7);
      checks++; if (bus.ic_enable !== exp_en) begin failures++; $display("FAIL full ic_enable cycle %0d: got %b want %b", k, bus.ic_enable, exp_en); end
      if (k >= 2) begin
        checks++; if (bus.instr_pc !== 32'h300) begin failures++; $display("FAIL full held instr_pc cycle %0d: got %h want 00000300", k, bus.instr_pc); end
      end
    end
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    checks++; if (bus.instr_pc !== 32'h304) begin failures++; $display("FAIL full after pop instr_pc: got %h want 00000304", bus.instr_pc); end
    @(negedge clk);
    checks++; if (bus.ic_enable !== 1'b1) begin failures++; $display("FAIL full refill ic_enable: got %b want 1", bus.ic_enable); end
    checks++; if (bus.ic_address !== 32'h310) begin failures++; $display("FAIL full refill ic_address: got %h want 00000310", bus.ic_address); end
    for (int k = 15; k <= 18; k++) begin
      @(negedge clk);
      checks++; if (bus.ic_enable !== 1'b0) begin failures++; $display("FAIL full extra issue cycle %0d: got %b want 0", k, bus.ic_enable); end
    end
  endtask

  task automatic test_redirect_fill();
    restart(32'h20C, 1'b1);
    @(negedge clk);
    checks++; if (bus.ic_address !== 32'h20C) begin failures++; $display("FAIL rdfill ic_address: got %h want 0000020c", bus.ic_address); end
    @(negedge clk);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h400;
    @(negedge clk);
    bus.redirect = 1'b0; miss_mode = 1'b0;
    for (int k = 3; k <= 8; k++) begin
      if (k > 3) @(negedge clk);
      checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rdfill stale instr_valid cycle %0d: got %b want 0", k, bus.instr_valid); end
      checks++; if (bus.ic_enable !== 1'b0) begin failures++; $display("FAIL rdfill early issue cycle %0d: got %b want 0", k, bus.ic_enable); end
    end
    @(negedge clk);
    checks++; if (bus.ic_enable !== 1'b1 || bus.ic_address !== 32'h400) begin failures++; $display("FAIL rdfill issue: got en=%b addr=%h want en=1 addr=00000400", bus.ic_enable, bus.ic_address); end
    @(negedge clk);
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h400) begin failures++; $display("FAIL rdfill first instr: got valid=%b pc=%h want valid=1 pc=00000400", bus.instr_valid, bus.instr_pc); end
    checks++; if (bus.instr !== (32'h400 ^ DATA_KEY)) begin failures++; $display("FAIL rdfill instr data: got %h want %h", bus.instr, 32'h400 ^ DATA_KEY); end
  endtask

  task automatic test_redirect_collision();
    restart(32'h500, 1'b0);
    bus.instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.ic_enable !== 1'b1 || bus.ic_address !== 32'h504) begin failures++; $display("FAIL coll setup request: got en=%b addr=%h want en=1 addr=00000504", bus.ic_enable, bus.ic_address); end
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h500) begin failures++; $display("FAIL coll setup head: got valid=%b pc=%h want valid=1 pc=00000500", bus.instr_valid, bus.instr_pc); end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h600; bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.redirect = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL coll flush instr_valid: got %b want 0 (pc %h)", bus.instr_valid, bus.instr_pc); end
    @(negedge clk);
    checks++; if (bus.ic_enable !== 1'b1 || bus.ic_address !== 32'h600) begin failures++; $display("FAIL coll reissue: got en=%b addr=%h want en=1 addr=00000600", bus.ic_enable, bus.ic_address); end
    @(negedge clk);
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h600) begin failures++; $display("FAIL coll first instr: got valid=%b pc=%h want valid=1 pc=00000600", bus.instr_valid, bus.instr_pc); end
  endtask

  task automatic test_wrap_and_async_reset();
    restart(32'hFFFF_FFFC, 1'b0);
    @(negedge clk);
    checks++; if (bus.ic_address !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap first addr: got %h want fffffffc", bus.ic_address); end
    @(negedge clk);
    checks++; if (bus.instr_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap first instr_pc: got %h want fffffffc", bus.instr_pc); end
    @(negedge clk);
    checks++; if (bus.ic_enable !== 1'b1 || bus.ic_address !== 32'h0) begin failures++; $display("FAIL wrap second request: got en=%b addr=%h want en=1 addr=00000000", bus.ic_enable, bus.ic_address); end
    @(negedge clk);
    checks++; if (bus.instr_pc !== 32'h0 || bus.instr !== DATA_KEY) begin failures++; $display("FAIL wrap second instr: got pc=%h data=%h want pc=00000000 data=%h", bus.instr_pc, bus.instr, DATA_KEY); end

    restart(32'h700, 1'b1);
    bus.instr_ready = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (bus.instr_valid !== 1'b1 || bus.ic_address !== 32'h700) begin failures++; $display("FAIL areset setup: got valid=%b addr=%h want valid=1 addr=00000700", bus.instr_valid, bus.ic_address); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.ic_enable !== 1'b0 || bus.ic_address !== 32'h0) begin failures++; $display("FAIL areset cache port: got en=%b addr=%h want en=0 addr=00000000", bus.ic_enable, bus.ic_address); end
    checks++; if (bus.instr_valid !== 1'b0 || bus.instr !== 32'h0 || bus.instr_pc !== 32'h0) begin failures++; $display("FAIL areset decode port: got valid=%b instr=%h pc=%h want all 0", bus.instr_valid, bus.instr, bus.instr_pc); end
    @(negedge clk);
    rst = 1'b1; miss_mode = 1'b0; bus.instr_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.ic_enable !== 1'b1 || bus.ic_address !== 32'h100) begin failures++; $display("FAIL areset restart: got en=%b addr=%h want en=1 addr=00000100", bus.ic_enable, bus.ic_address); end
  endtask

  initial begin
    test_reset();
    test_hit_stream();
    test_miss();
    test_backpressure();
    test_redirect_fill();
    test_redirect_collision();
    test_wrap_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
